qsfp_rd_capture: RTL
====================

// Module: qsfp_rd_capture
// PURPOSE
// - Downstream of the QSFP poller FSM. Consumes the I2C master read-data stream (Avalon-ST RX).
// - Each poller read byte goes to the shadow memory at a slot derived from {curr_rd_page, curr_rd_addr}.
// - Returns the per-byte rd_done / rd_done_ack handshake to the poller.
// - Flags timeouts and unmapped pages so the poller never hangs.
// PARAMETERS
// - MEM_AW       7       word address width of 64-bit shadow memory (128 words = 1 KiB)
// - TMO_W        20      width of byte-wait timeout counter
// - TMO_CYC      100000  clk cycles to wait for an RX byte before declaring timeout
// PORTS
// - clk            in   1   clock
// - reset          in   1   asynchronous, active-high
// - wren_logic     in   1   poller read window open; capture enabled
// - curr_rd_addr   in   8   QSFP byte address of the byte being read
// - curr_rd_page   in   8   QSFP page (00/02/03/20/21 mapped)
// - rd_done        out  1   byte captured (or timed out); held until rd_done_ack
// - rd_done_ack    in   1   poller acknowledge, level
// - wr_cnt_rst     in   1   clear byte counter (new poll sweep)
// - rx_data        in   8   I2C master RX byte
// - rx_valid       in   1   RX byte valid
// - rx_ready       out  1   RX accept
// - mem_wr_en      out  1   shadow-memory write strobe, 1 cycle
// - mem_wr_addr    out  MEM_AW  word address
// - mem_wr_data    out  64  byte replicated across 8 lanes
// - mem_wr_be      out  8   one-hot byte enable
// - page_done      out  1   1-cycle pulse when byte addr 255 is written
// - byte_cnt       out  16  bytes written since wr_cnt_rst, saturating at 16'hFFFF
// - err_tmo        out  1   sticky timeout flag, cleared by wr_cnt_rst
// - err_page       out  1   sticky unmapped-page flag, cleared by wr_cnt_rst
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; timeout counter 0.
// - Slot map to byte offset (10 bits):
//   - page00: addr -> 0x000+addr
//   - page02: 0x100+(addr-128)
//   - page03: 0x180+(addr-128)
//   - page20: 0x200+(addr-128)
//   - page21: 0x280+(addr-128)
//   - Addr <128 on non-00 pages, or any other page, is unmapped.
//   - Word address = offset[9:3]; be = 1<<offset[2:0].
// - IDLE: rx_ready=1; stray RX bytes are drained and discarded (no write, no rd_done).
//   - Covers the trailing NACK byte after the poller pauses.
//   - Go to WAIT_DATA when wren_logic=1.
// - WAIT_DATA: rx_ready=1; timeout counter increments each cycle.
//   - rx_valid: latch byte; go to WRITE.
//   - Counter reaches TMO_CYC-1 with no byte: set err_tmo; go to DONE with no write.
//   - wren_logic drops: go to IDLE.
// - WRITE: rx_ready=0.
//   - Mapped address: mem_wr_en=1 for one cycle; byte_cnt++.
//   - page_done pulses if curr_rd_addr==255.
//   - Unmapped address: no write; set err_page.
//   - Go to DONE. Latency: rx beat to mem_wr_en = 1 clk; to rd_done = 2 clk.
// - DONE: rd_done=1; rx_ready=0. When rd_done_ack=1, go to ACK_WAIT.
// - ACK_WAIT: rd_done=0. When rd_done_ack=0, go to WAIT_DATA if wren_logic=1, else IDLE.
// - Address/page are sampled in the WRITE cycle; the poller holds them stable until it sees rd_done.
// - Simultaneous events:
//   - wr_cnt_rst beats a same-cycle increment: byte_cnt=0.
//   - wr_cnt_rst beats a same-cycle error set: flags cleared.
// - Reset mid-operation: immediate return to IDLE; any pending write is lost; rd_done deasserts.
// STRUCTURE
// - Package qsfp_shadow_pkg: state enum, page-code constants (8'h00/02/03/20/21),
//   slot base offsets, TFR constants shared with the poller.
// - Sub-module qsfp_slot_map: combinational {page,addr} -> {mapped, offset[9:0]}; reused by the CSR read path.
// TESTING
// - page00 addr 0x05, rx 0xA5 -> mem_wr_addr=0, be=8'h20, data=64'hA5A5..A5, rd_done 2 clk after beat.
// - page21 addr 255, rx 0x3C -> offset 0x2FF, addr=7'h5F, be=8'h80; page_done pulse; byte_cnt+1.
// - page02 addr 0x10 -> no mem_wr_en; err_page=1; rd_done still asserted; cleared by wr_cnt_rst.
// - wren_logic=1, no rx_valid for TMO_CYC cycles -> err_tmo=1, rd_done=1, no write.
// - IDLE with rx_valid pulse 0x77 -> consumed (rx_ready=1), no write, no rd_done.
// - Reset asserted in DONE -> rd_done=0 same cycle; next wren_logic restarts cleanly.

Source files
------------

// File: rtl/qsfp_shadow_pkg.sv
// qsfp_shadow_pkg: shared types and constants for the QSFP shadow-memory capture path
package qsfp_shadow_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_DATA, WRITE, DONE, ACK_WAIT} state_t;
  localparam logic [7:0] PG00 = 8'h00, PG02 = 8'h02, PG03 = 8'h03, PG20 = 8'h20, PG21 = 8'h21;
  localparam logic [9:0] BASE02 = 10'h100, BASE03 = 10'h180, BASE20 = 10'h200, BASE21 = 10'h280;
  // I2C master command-word flag bits, shared with the poller
  localparam int TFR_START_BIT = 8;
  localparam int TFR_STOP_BIT  = 9;
endpackage

// File: rtl/qsfp_slot_map.sv
// qsfp_slot_map: maps {page, addr} to a 10-bit shadow-memory byte offset
module qsfp_slot_map
  import qsfp_shadow_pkg::*;
(
  input  logic [7:0] page,
  input  logic [7:0] addr,
  output logic       mapped,
  output logic [9:0] offset
);
  logic [9:0] base;
  logic       hi_page;
  always_comb begin
    base    = page == PG02 ? BASE02 : page == PG03 ? BASE03 : page == PG20 ? BASE20 : BASE21;
    hi_page = page inside {PG02, PG03, PG20, PG21};
    mapped  = page == PG00 || (hi_page && addr[7]);
    offset  = !mapped ? '0 : page == PG00 ? {2'b00, addr} : base | {3'b000, addr[6:0]};
  end
endmodule

// File: rtl/qsfp_rd_capture.sv
// qsfp_rd_capture: captures poller read bytes from the I2C RX stream into the shadow memory
module qsfp_rd_capture
  import qsfp_shadow_pkg::*;
#(
  parameter int MEM_AW  = 7,
  parameter int TMO_W   = 20,
  parameter int TMO_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wren_logic,
  input  logic [7:0]        curr_rd_addr,
  input  logic [7:0]        curr_rd_page,
  output logic              rd_done,
  input  logic              rd_done_ack,
  input  logic              wr_cnt_rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_wr_en,
  output logic [MEM_AW-1:0] mem_wr_addr,
  output logic [63:0]       mem_wr_data,
  output logic [7:0]        mem_wr_be,
  output logic              page_done,
  output logic [15:0]       byte_cnt,
  output logic              err_tmo,
  output logic              err_page
);
  state_t           state, nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       byte_q;
  logic             mapped, wr, tmo_hit;
  logic [9:0]       offset;

  qsfp_slot_map u_map (
    .page   (curr_rd_page),
    .addr   (curr_rd_addr),
    .mapped (mapped),
    .offset (offset)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    tmo_hit = state == WAIT_DATA && !rx_valid && wren_logic && tmo_cnt == TMO_W'(TMO_CYC - 1);
    nxt     = state;
    case (state)
      IDLE:      nxt = wren_logic ? WAIT_DATA : IDLE;
      WAIT_DATA: nxt = rx_valid ? WRITE : !wren_logic ? IDLE : tmo_hit ? DONE : WAIT_DATA;
      WRITE:     nxt = DONE;
      DONE:      nxt = rd_done_ack ? ACK_WAIT : DONE;
      ACK_WAIT:  nxt = rd_done_ack ? ACK_WAIT : wren_logic ? WAIT_DATA : IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // write-side outputs are zeroed outside the write strobe so idle buses stay quiet
  always_comb begin
    wr          = state == WRITE && mapped;
    rx_ready    = !reset && (state == IDLE || state == WAIT_DATA);
    rd_done     = state == DONE;
    mem_wr_en   = wr;
    mem_wr_addr = wr ? MEM_AW'(offset[9:3]) : '0;
    mem_wr_data = wr ? {8{byte_q}} : '0;
    mem_wr_be   = wr ? 8'b1 << offset[2:0] : '0;
    page_done   = wr && curr_rd_addr == 8'hFF;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tmo_cnt  <= '0;
      byte_q   <= '0;
      byte_cnt <= '0;
      err_tmo  <= 1'b0;
      err_page <= 1'b0;
    end else begin
      tmo_cnt  <= state == WAIT_DATA ? tmo_cnt + TMO_W'(1) : '0;
      if (state == WAIT_DATA && rx_valid) byte_q <= rx_data;
      byte_cnt <= wr_cnt_rst ? '0 : wr && byte_cnt != 16'hFFFF ? byte_cnt + 16'd1 : byte_cnt;
      err_tmo  <= !wr_cnt_rst && (err_tmo || tmo_hit);
      err_page <= !wr_cnt_rst && (err_page || (state == WRITE && !mapped));
    end
endmodule
